// File: rtl/word_align_ctrl.sv
// Receive-side word-alignment controller: slips the CDIVX divider via ALIGNWD
// until the deserialized word matches the training pattern, then holds lock.
module word_align_ctrl #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] TRAIN_PAT = 8'hE4,
    parameter int unsigned       MATCH_CNT = 4,
    parameter int unsigned       SETTLE    = 6,
    parameter int unsigned       MAX_SLIPS = 16,
    parameter int unsigned       LOSS_CNT  = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [DATA_W-1:0] DATAIN,
    output logic              ALIGNWD,
    output logic              BUSY,
    output logic              LOCKED,
    output logic              FAIL,
    output logic [4:0]        SLIPCNT
);

    localparam logic [3:0] MATCH_LAST  = 4'(MATCH_CNT - 1);
    localparam logic [5:0] SETTLE_LOAD = 6'(SETTLE - 1);
    localparam logic [4:0] SLIP_MAX    = 5'(MAX_SLIPS);
    localparam bit         LOSS_EN     = (LOSS_CNT != 0);
    localparam logic [3:0] LOSS_LAST   = 4'((LOSS_CNT == 0) ? 0 : LOSS_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCK,
        ST_FAIL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] match_q, match_d;
    logic [3:0] loss_q,  loss_d;
    logic [5:0] settle_q, settle_d;
    logic [4:0] slip_q,  slip_d;
    logic       hit;
    logic       restart;

    // An X/Z word makes the compare unknown, which falls through to the mismatch path.
    assign hit = (DATAIN == TRAIN_PAT);

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        loss_d   = loss_q;
        settle_d = settle_q;
        slip_d   = slip_q;
        restart  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_CHECK;
                    slip_d  = '0;
                    match_d = '0;
                end
            end

            ST_CHECK: begin
                if (hit) begin
                    if (match_q == MATCH_LAST) begin
                        state_d = ST_LOCK;
                        match_d = '0;
                        loss_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    match_d = '0;
                    if (slip_q == SLIP_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                        slip_d  = slip_q + 1'b1;
                    end
                end
            end

            ST_SLIP: begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_LOAD;
            end

            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                    match_d = '0;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end

            ST_LOCK: begin
                restart = START;
                if (LOSS_EN) begin
                    if (hit) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_LAST) begin
                        restart = 1'b1;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
                // START and loss of lock together collapse into one restart.
                if (restart) begin
                    state_d = ST_CHECK;
                    slip_d  = '0;
                    match_d = '0;
                    loss_d  = '0;
                end
            end

            ST_FAIL: begin
                if (START) begin
                    state_d = ST_CHECK;
                    slip_d  = '0;
                    match_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            match_q  <= '0;
            loss_q   <= '0;
            settle_q <= '0;
            slip_q   <= '0;
            ALIGNWD  <= 1'b0;
            BUSY     <= 1'b0;
            LOCKED   <= 1'b0;
            FAIL     <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            settle_q <= settle_d;
            slip_q   <= slip_d;
            ALIGNWD  <= (state_d == ST_SLIP);
            BUSY     <= (state_d == ST_CHECK) || (state_d == ST_SLIP) || (state_d == ST_SETTLE);
            LOCKED   <= (state_d == ST_LOCK);
            FAIL     <= (state_d == ST_FAIL);
        end
    end

    assign SLIPCNT = slip_q;

endmodule
